// File: rtl/writeback_regfile.sv
// ============================================================================
// writeback_regfile : Y86-64 writeback stage (W register, register file, retire/halt state)
// Optional macro WB_BYPASS_EN: read ports see the value committing this cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int AW     = 4,
  parameter int NREG   = 15,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     bubble_i,
  input  logic [3:0]               icode_i,
  input  logic [2:0]               stat_i,
  input  logic [DATA_W-1:0]        valE_i,
  input  logic [DATA_W-1:0]        valM_i,
  input  logic [AW-1:0]            dstE_i,
  input  logic [AW-1:0]            dstM_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [3:0]               W_icode_o,
  output logic [2:0]               W_stat_o,
  output logic [DATA_W-1:0]        W_valE_o,
  output logic [DATA_W-1:0]        W_valM_o,
  output logic [AW-1:0]            W_dstE_o,
  output logic [AW-1:0]            W_dstM_o,
  output logic                     W_valid_o,
  output logic                     halted_o,
  output logic [CNT_W-1:0]         instret_o
);

  localparam logic [3:0]    c_INOP  = 4'h1;
  localparam logic [2:0]    c_AOK   = 3'd1;
  localparam logic [AW-1:0] c_RNONE = {AW{1'b1}};
  localparam logic [AW:0]   c_NREG  = (AW+1)'(NREG);

  logic [3:0]        icode_q;
  logic [2:0]        stat_q;
  logic [DATA_W-1:0] valE_q, valM_q;
  logic [AW-1:0]     dstE_q, dstM_q;
  logic              valid_q, done_q, halted_q;
  logic [CNT_W-1:0]  instret_q;
  logic [DATA_W-1:0] rf_q [NREG];

  logic w_commit, w_dstE_ok, w_dstM_ok, w_weE, w_weM;

  assign w_commit  = valid_q & (stat_q == c_AOK) & ~halted_q & ~done_q;
  assign w_dstE_ok = (dstE_q != c_RNONE) & ({1'b0, dstE_q} < c_NREG);
  assign w_dstM_ok = (dstM_q != c_RNONE) & ({1'b0, dstM_q} < c_NREG);
  // Same destination: valM takes the port, valE is dropped.
  assign w_weE     = w_commit & w_dstE_ok & ~(w_dstM_ok & (dstE_q == dstM_q));
  assign w_weM     = w_commit & w_dstM_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icode_q   <= c_INOP;
      stat_q    <= c_AOK;
      valE_q    <= '0;
      valM_q    <= '0;
      dstE_q    <= c_RNONE;
      dstM_q    <= c_RNONE;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (stall_i) begin
        done_q <= done_q | w_commit;
      end else if (bubble_i) begin
        icode_q <= c_INOP;
        stat_q  <= c_AOK;
        valE_q  <= '0;
        valM_q  <= '0;
        dstE_q  <= c_RNONE;
        dstM_q  <= c_RNONE;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        icode_q <= icode_i;
        stat_q  <= stat_i;
        valE_q  <= valE_i;
        valM_q  <= valM_i;
        dstE_q  <= dstE_i;
        dstM_q  <= dstM_i;
        valid_q <= 1'b1;
        done_q  <= 1'b0;
      end
      if (valid_q && (stat_q != c_AOK)) halted_q <= 1'b1;
      if (w_commit) instret_q <= instret_q + CNT_W'(1);
      if (w_weE) rf_q[dstE_q] <= valE_q;
      if (w_weM) rf_q[dstM_q] <= valM_q;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic              w_ok;
    logic [DATA_W-1:0] w_data;
    assign w_addr = rd_addr_i[k*AW +: AW];
    assign w_ok   = (w_addr != c_RNONE) & ({1'b0, w_addr} < c_NREG);
    always_comb begin
      w_data = '0;
      if (w_ok) begin
        w_data = rf_q[w_addr];
`ifdef WB_BYPASS_EN
        if (w_weM && (w_addr == dstM_q))      w_data = valM_q;
        else if (w_weE && (w_addr == dstE_q)) w_data = valE_q;
`endif
      end
    end
    assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
  end

  assign W_icode_o = icode_q;
  assign W_stat_o  = stat_q;
  assign W_valE_o  = valE_q;
  assign W_valM_o  = valM_q;
  assign W_dstE_o  = dstE_q;
  assign W_dstM_o  = dstM_q;
  assign W_valid_o = valid_q;
  assign halted_o  = halted_q;
  assign instret_o = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
// tb_writeback_regfile : directed self-checking bench for writeback_regfile
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_regfile;

  localparam int DATA_W = 64;
  localparam int AW     = 4;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, stall, bubble;
  logic [3:0]        icode;
  logic [2:0]        stat;
  logic [DATA_W-1:0] valE, valM;
  logic [AW-1:0]     dstE, dstM;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [3:0]        W_icode;
  logic [2:0]        W_stat;
  logic [DATA_W-1:0] W_valE, W_valM;
  logic [AW-1:0]     W_dstE, W_dstM;
  logic              W_valid, halted;
  logic [CNT_W-1:0]  instret;

  int checks = 0;
  int failures = 0;

  writeback_regfile #(.DATA_W(DATA_W), .AW(AW), .NREG(15), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
    .icode_i(icode), .stat_i(stat), .valE_i(valE), .valM_i(valM),
    .dstE_i(dstE), .dstM_i(dstM), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .W_icode_o(W_icode), .W_stat_o(W_stat), .W_valE_o(W_valE), .W_valM_o(W_valM),
    .W_dstE_o(W_dstE), .W_dstM_o(W_dstM), .W_valid_o(W_valid),
    .halted_o(halted), .instret_o(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] ic, input logic [2:0] st,
                      input logic [AW-1:0] de, input logic [63:0] ve,
                      input logic [AW-1:0] dm, input logic [63:0] vm);
    bubble = 1'b0;
    icode = ic; stat = st; dstE = de; valE = ve; dstM = dm; valM = vm;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    load(4'h0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0);
    rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    bubble = 1'b1;
    set_rd(4'd0, 4'd14);
    chk("rst_icode",   W_icode, 4'h1);
    chk("rst_dstE",    W_dstE, 4'hF);
    chk("rst_valid",   W_valid, 1'b0);
    chk("rst_rd0",     rd_data[63:0], 64'h0);
    chk("rst_rd1",     rd_data[127:64], 64'h0);
    chk("rst_halted",  halted, 1'b0);
    chk("rst_instret", instret, 4'd0);

    // Basic commit
    load(4'h6, 3'd1, 4'd3, 64'h10, 4'hF, 64'h0);
    set_rd(4'd3, 4'hF);
    tick();
    bubble = 1'b1;
    #1;
    chk("basic_Wicode", W_icode, 4'h6);
    chk("basic_Wvalid", W_valid, 1'b1);
    chk("basic_WvalE",  W_valE, 64'h10);
`ifdef WB_BYPASS_EN
    chk("basic_rd_early", rd_data[63:0], 64'h10);
`else
    chk("basic_rd_early", rd_data[63:0], 64'h0);
`endif
    tick();
    chk("basic_rd",      rd_data[63:0], 64'h10);
    chk("basic_rnone",   rd_data[127:64], 64'h0);
    chk("basic_instret", instret, 4'd1);

    // Same destination on both ports
    load(4'h5, 3'd1, 4'd4, 64'h5, 4'd4, 64'h9);
    set_rd(4'd3, 4'd4);
    tick();
    bubble = 1'b1;
    tick();
    chk("same_reg4",    rd_data[127:64], 64'h9);
    chk("same_reg3",    rd_data[63:0], 64'h10);
    chk("same_instret", instret, 4'd2);

    // Stall: one commit across three held cycles
    load(4'h6, 3'd1, 4'd2, 64'h55, 4'd5, 64'h66);
    tick();
    stall = 1'b1;
    load(4'hA, 3'd1, 4'd7, 64'hDEAD, 4'd8, 64'hBEEF);
    tick(); tick(); tick();
    chk("stall_instret", instret, 4'd3);
    chk("stall_Wicode",  W_icode, 4'h6);
    chk("stall_WvalE",   W_valE, 64'h55);
    chk("stall_WdstM",   W_dstM, 4'd5);
    stall = 1'b0;
    bubble = 1'b1;
    tick();
    set_rd(4'd2, 4'd5);
    chk("stall_reg2",  rd_data[63:0], 64'h55);
    chk("stall_reg5",  rd_data[127:64], 64'h66);
    chk("bubble_valid", W_valid, 1'b0);
    tick();
    chk("bubble_instret", instret, 4'd3);

    // Halt
    load(4'h0, 3'd2, 4'd2, 64'h7, 4'hF, 64'h0);
    tick();
    load(4'h6, 3'd1, 4'd1, 64'h77, 4'hF, 64'h0);
    tick();
    bubble = 1'b1;
    set_rd(4'd2, 4'd1);
    chk("halt_halted",  halted, 1'b1);
    chk("halt_reg2",    rd_data[63:0], 64'h55);
    chk("halt_instret", instret, 4'd3);
    chk("halt_Wloads",  W_valE, 64'h77);
    tick(); tick();
    chk("halt_reg1",     rd_data[127:64], 64'h0);
    chk("halt_instret2", instret, 4'd3);
    chk("halt_sticky",   halted, 1'b1);

    // Reset clears everything, then the counter wraps at 16 commits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(4'd4, 4'd6);
    chk("rst2_reg4",   rd_data[63:0], 64'h0);
    chk("rst2_halted", halted, 1'b0);
    for (int i = 0; i < 16; i++) begin
      load(4'h6, 3'd1, 4'd6, 64'(i + 1), 4'hF, 64'h0);
      tick();
    end
    chk("wrap_15", instret, 4'd15);
    bubble = 1'b1;
    tick();
    chk("wrap_0",    instret, 4'd0);
    chk("wrap_reg6", rd_data[127:64], 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
